// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, host and data-memory buses around the DM port arbiter.
// The arbiter attaches through the slave modport; the surrounding system
// (CPU, host requester and the memory itself) attaches through master.
interface dmem_port_arbiter_if #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 4
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  // CPU side
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  // Host request side
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [LW-1:0] fifo_level;

  // Data-memory port
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata, fifo_level,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata, fifo_level,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU and a host requester.
// Host requests are queued in a small FIFO and issued in cycles the CPU leaves
// idle. If the FIFO head is held off by the CPU for MAX_WAIT cycles, the next
// cycle stalls the CPU and hands the port to the host (forced slot).
module dmem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 16
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WaitMax   = CW'(MAX_WAIT);

  typedef enum logic [0:0] {
    StNormal,
    StForce
  } state_e;

  // Request storage; contents need no reset, validity is tracked by level_q.
  logic          ent_we_q    [FIFO_DEPTH];
  logic [AW-1:0] ent_addr_q  [FIFO_DEPTH];
  logic [DW-1:0] ent_wdata_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  state_e        state_q, state_d;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          grant_cpu;
  logic          grant_host;
  logic          stall;
  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  assign full       = (level_q == LevelFull);
  assign empty      = (level_q == '0);
  assign head_we    = ent_we_q[rd_ptr_q];
  assign head_addr  = ent_addr_q[rd_ptr_q];
  assign head_wdata = ent_wdata_q[rd_ptr_q];

  // Full blocks a push even when the head pops in the same cycle.
  assign bus.host_ready = ~full & ~rst;
  assign push           = bus.host_valid & bus.host_ready;
  assign pop            = grant_host;

  // FIFO pointer and occupancy next-state; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Request storage write on an accepted host transfer.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_we_q[wr_ptr_q]    <= bus.host_we;
      ent_addr_q[wr_ptr_q]  <= bus.host_addr;
      ent_wdata_q[wr_ptr_q] <= bus.host_wdata;
    end
  end

  // Arbitration FSM: grants from registered state, plus the starvation counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      StNormal: begin
        if (bus.cpu_cs) begin
          grant_cpu = 1'b1;
        end else if (!empty) begin
          grant_host = 1'b1;
        end
      end
      StForce: begin
        stall      = 1'b1;
        grant_host = ~empty;
      end
    endcase

    // Nothing reaches the memory port while reset is held.
    if (rst) begin
      grant_cpu  = 1'b0;
      grant_host = 1'b0;
      stall      = 1'b0;
    end

    if (grant_host || empty) begin
      wait_cnt_d = '0;
      state_d    = StNormal;
    end else if (grant_cpu) begin
      // Head present but the CPU took the port: one more blocked cycle.
      if (wait_cnt_q != WaitMax) begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
      if (wait_cnt_d == WaitMax) begin
        state_d = StForce;
      end
    end
  end

  // Memory port mux and pass-through outputs.
  always_comb begin
    bus.mem_cs    = grant_cpu | grant_host;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (grant_host) begin
      bus.mem_we    = head_we;
      bus.mem_addr  = head_addr;
      bus.mem_wdata = head_wdata;
    end else if (grant_cpu) begin
      bus.mem_we = bus.cpu_we;
    end
    bus.cpu_rdata   = bus.mem_rdata;
    bus.cpu_stall   = stall;
    bus.fifo_level  = level_q;
    bus.host_rvalid = rvalid_q;
    bus.host_rdata  = rdata_q;
  end

  // Control state register: FIFO pointers, occupancy, wait counter, FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wait_cnt_q <= '0;
      state_q    <= StNormal;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wait_cnt_q <= wait_cnt_d;
      state_q    <= state_d;
    end
  end

  // Host read return: capture memory data in the grant cycle, pulse valid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop & ~head_we;
      if (pop && !head_we) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifndef SYNTHESIS
  a_level_bound : assert property (@(posedge clk) disable iff (rst) level_q <= LevelFull);
  a_force_sat   : assert property (@(posedge clk) disable iff (rst)
                                   (state_q == StForce) == (wait_cnt_q == WaitMax));
  a_force_head  : assert property (@(posedge clk) disable iff (rst)
                                   (state_q == StForce) |-> !empty);
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXW  = 16;
  localparam int          MEMW  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

  dmem_port_arbiter #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural data memory attached to the arbiter's port.
  logic [DW-1:0] dm [MEMW];
  bit            clear_dm;
  assign bus.mem_rdata = dm[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (clear_dm) begin
      for (int i = 0; i < MEMW; i++) dm[i] <= '0;
    end else if (bus.mem_cs && bus.mem_we) begin
      dm[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    chk32(name, 32'(act), 32'(exp));
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // ---------------- Reference model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          mq[$];
  int            blocked;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [MEMW];
  bit            p_force, p_host_g, p_cpu_g;

  function automatic void model_reset();
    mq.delete();
    blocked  = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endfunction

  function automatic void predict();
    p_force  = (mq.size() > 0) && (blocked >= MAXW);
    p_host_g = (mq.size() > 0) && (p_force || !bus.cpu_cs);
    p_cpu_g  = bus.cpu_cs && !p_force;
  endfunction

  function automatic void compare_model();
    chk1("model mem_cs", bus.mem_cs, p_host_g || p_cpu_g);
    if (p_host_g) begin
      chk1("model host mem_we", bus.mem_we, mq[0].we);
      chk32("model host mem_addr", bus.mem_addr, mq[0].addr);
      if (mq[0].we) chk32("model host mem_wdata", bus.mem_wdata, mq[0].wdata);
    end else if (p_cpu_g) begin
      chk1("model cpu mem_we", bus.mem_we, bus.cpu_we);
      chk32("model cpu mem_addr", bus.mem_addr, bus.cpu_addr);
      if (bus.cpu_we) chk32("model cpu mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      else chk32("model cpu_rdata", bus.cpu_rdata, ref_mem[widx(bus.cpu_addr)]);
    end
    chk1("model cpu_stall", bus.cpu_stall, p_force);
    chk1("model host_ready", bus.host_ready, mq.size() < DEPTH);
    chk32("model fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
    chk1("model host_rvalid", bus.host_rvalid, m_rvalid);
    chk32("model host_rdata", bus.host_rdata, m_rdata);
  endfunction

  function automatic void update();
    int   n;
    bit   pushed;
    req_t h;
    req_t nr;
    n        = mq.size();
    pushed   = bus.host_valid && (n < DEPTH);
    m_rvalid = 1'b0;
    if (p_cpu_g && bus.cpu_we) ref_mem[widx(bus.cpu_addr)] = bus.cpu_wdata;
    if (p_host_g) begin
      h = mq.pop_front();
      if (h.we) begin
        ref_mem[widx(h.addr)] = h.wdata;
      end else begin
        m_rvalid = 1'b1;
        m_rdata  = ref_mem[widx(h.addr)];
      end
      blocked = 0;
    end else if (n > 0) begin
      if (blocked < MAXW) blocked++;
    end else begin
      blocked = 0;
    end
    if (pushed) begin
      nr.we    = bus.host_we;
      nr.addr  = bus.host_addr;
      nr.wdata = bus.host_wdata;
      mq.push_back(nr);
    end
  endfunction

  // ---------------- Cycle helpers ----------------
  task automatic sample();
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic tick();
    sample();
    compare_model();
    advance();
  endtask

  task automatic idle_inputs();
    bus.cpu_cs     = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.host_valid = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
  endtask

  // Assert reset part-way through a cycle and check the same-cycle outputs.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("rst host_ready", bus.host_ready, 1'b0);
    chk1("rst mem_cs", bus.mem_cs, 1'b0);
    chk1("rst mem_we", bus.mem_we, 1'b0);
    chk1("rst cpu_stall", bus.cpu_stall, 1'b0);
    chk32("rst fifo_level", 32'(bus.fifo_level), 32'd0);
    chk1("rst host_rvalid", bus.host_rvalid, 1'b0);
    chk32("rst host_rdata", bus.host_rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts any write to the addresses queued just before the mid-run reset.
  bit watch6;
  int hits6;
  always @(negedge clk) begin
    if (watch6 && bus.mem_cs && bus.mem_we &&
        bus.mem_addr >= 32'h30 && bus.mem_addr <= 32'h38) hits6++;
  end

  // ---------------- Directed vector table ----------------
  typedef struct {
    bit          cpu_cs;
    bit          cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    bit          host_valid;
    bit          host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    bit          e_cs;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_stall;
    bit          e_ready;
    int          e_level;
    bit          e_rvalid;
    logic [31:0] e_rdata;
    bit          chk_rd;
    logic [31:0] e_cpu_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clear_dm = 1'b1;
    watch6   = 1'b0;
    hits6    = 0;
    for (int i = 0; i < MEMW; i++) ref_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clear_dm = 1'b0;
    rst      = 1'b0;

    // Idle-CPU host write, CPU write, host read-back, CPU reads.
    //         cpu: cs we addr    wdata     host: v we addr   wdata
    //         exp: cs we addr    wdata     stall rdy lvl rv rdata     chk_rd cpu_rdata
    vt[0] = '{0, 0, 32'h0, 32'h0,     1, 1, 32'h0, 32'h1234,
              0, 0, 32'h0, 32'h0,     0, 1, 0, 0, 32'h0,    0, 32'h0};
    vt[1] = '{0, 0, 32'h0, 32'h0,     0, 0, 32'h0, 32'h0,
              1, 1, 32'h0, 32'h1234,  0, 1, 1, 0, 32'h0,    0, 32'h0};
    vt[2] = '{1, 1, 32'h8, 32'hCAFE,  1, 0, 32'h8, 32'h0,
              1, 1, 32'h8, 32'hCAFE,  0, 1, 0, 0, 32'h0,    0, 32'h0};
    vt[3] = '{0, 0, 32'h0, 32'h0,     0, 0, 32'h0, 32'h0,
              1, 0, 32'h8, 32'h0,     0, 1, 1, 0, 32'h0,    0, 32'h0};
    vt[4] = '{0, 0, 32'h0, 32'h0,     0, 0, 32'h0, 32'h0,
              0, 0, 32'h0, 32'h0,     0, 1, 0, 1, 32'hCAFE, 0, 32'h0};
    vt[5] = '{1, 0, 32'h8, 32'h0,     0, 0, 32'h0, 32'h0,
              1, 0, 32'h8, 32'h0,     0, 1, 0, 0, 32'hCAFE, 1, 32'hCAFE};
    vt[6] = '{1, 0, 32'h0, 32'h0,     0, 0, 32'h0, 32'h0,
              1, 0, 32'h0, 32'h0,     0, 1, 0, 0, 32'hCAFE, 1, 32'h1234};

    for (int i = 0; i < NV; i++) begin
      bus.cpu_cs     = vt[i].cpu_cs;
      bus.cpu_we     = vt[i].cpu_we;
      bus.cpu_addr   = vt[i].cpu_addr;
      bus.cpu_wdata  = vt[i].cpu_wdata;
      bus.host_valid = vt[i].host_valid;
      bus.host_we    = vt[i].host_we;
      bus.host_addr  = vt[i].host_addr;
      bus.host_wdata = vt[i].host_wdata;
      sample();
      chk1($sformatf("vec%0d mem_cs", i), bus.mem_cs, vt[i].e_cs);
      if (vt[i].e_cs) begin
        chk1($sformatf("vec%0d mem_we", i), bus.mem_we, vt[i].e_we);
        chk32($sformatf("vec%0d mem_addr", i), bus.mem_addr, vt[i].e_addr);
        if (vt[i].e_we) chk32($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vt[i].e_wdata);
      end
      chk1($sformatf("vec%0d cpu_stall", i), bus.cpu_stall, vt[i].e_stall);
      chk1($sformatf("vec%0d host_ready", i), bus.host_ready, vt[i].e_ready);
      chk32($sformatf("vec%0d fifo_level", i), 32'(bus.fifo_level), 32'(vt[i].e_level));
      chk1($sformatf("vec%0d host_rvalid", i), bus.host_rvalid, vt[i].e_rvalid);
      chk32($sformatf("vec%0d host_rdata", i), bus.host_rdata, vt[i].e_rdata);
      if (vt[i].chk_rd) chk32($sformatf("vec%0d cpu_rdata", i), bus.cpu_rdata, vt[i].e_cpu_rdata);
      advance();
    end
    idle_inputs();

    // Mid-cycle reset clears host_rdata (holding 0xCAFE) and the queue.
    apply_reset();
    sample();
    chk1("post-rst host_ready", bus.host_ready, 1'b1);
    chk32("post-rst fifo_level", 32'(bus.fifo_level), 32'd0);
    chk1("post-rst cpu_stall", bus.cpu_stall, 1'b0);
    chk1("post-rst host_rvalid", bus.host_rvalid, 1'b0);
    chk32("post-rst host_rdata", bus.host_rdata, 32'd0);
    compare_model();
    advance();

    // Forced slot: CPU busy every cycle, one host write waits MAX_WAIT cycles.
    bus.cpu_cs   = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    push_req(1'b1, 32'h4, 32'hAB);
    tick();
    bus.host_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      sample();
      if (c <= 16) begin
        chk1($sformatf("force c%0d cpu_stall", c), bus.cpu_stall, 1'b0);
        chk32($sformatf("force c%0d mem_addr", c), bus.mem_addr, 32'h10);
      end else if (c == 17) begin
        chk1("force c17 cpu_stall", bus.cpu_stall, 1'b1);
        chk1("force c17 mem_we", bus.mem_we, 1'b1);
        chk32("force c17 mem_addr", bus.mem_addr, 32'h4);
        chk32("force c17 mem_wdata", bus.mem_wdata, 32'hAB);
      end else begin
        chk1("force c18 cpu_stall", bus.cpu_stall, 1'b0);
        chk32("force c18 fifo_level", 32'(bus.fifo_level), 32'd0);
      end
      compare_model();
      advance();
    end

    // Fill the FIFO behind a busy CPU, reject a 5th, then drain in order.
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 32'h20 + 32'(4 * i), 32'h100 + 32'(i));
      tick();
    end
    push_req(1'b1, 32'h40, 32'hBAD);
    sample();
    chk32("full fifo_level", 32'(bus.fifo_level), 32'd4);
    chk1("full host_ready", bus.host_ready, 1'b0);
    compare_model();
    advance();
    bus.host_valid = 1'b0;
    bus.cpu_cs     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk1($sformatf("drain%0d mem_cs", i), bus.mem_cs, 1'b1);
      chk32($sformatf("drain%0d mem_addr", i), bus.mem_addr, 32'h20 + 32'(4 * i));
      chk32($sformatf("drain%0d mem_wdata", i), bus.mem_wdata, 32'h100 + 32'(i));
      chk32($sformatf("drain%0d fifo_level", i), 32'(bus.fifo_level), 32'(4 - i));
      compare_model();
      advance();
    end
    sample();
    chk1("drained mem_cs", bus.mem_cs, 1'b0);
    compare_model();
    advance();

    // Reset discards three queued writes; the next push issues normally.
    bus.cpu_cs   = 1'b1;
    bus.cpu_addr = 32'h10;
    watch6       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_req(1'b1, 32'h30 + 32'(4 * i), 32'hD00 + 32'(i));
      tick();
    end
    bus.host_valid = 1'b0;
    apply_reset();
    bus.cpu_cs = 1'b0;
    repeat (5) tick();
    push_req(1'b1, 32'h50, 32'h5555);
    tick();
    bus.host_valid = 1'b0;
    sample();
    chk1("after-rst push mem_cs", bus.mem_cs, 1'b1);
    chk1("after-rst push mem_we", bus.mem_we, 1'b1);
    chk32("after-rst push mem_addr", bus.mem_addr, 32'h50);
    compare_model();
    advance();
    watch6 = 1'b0;
    chk32("discarded writes issued", 32'(hits6), 32'd0);

    // Random traffic, alternating heavy and light CPU load.
    for (int seg = 0; seg < 6; seg++) begin
      int cpu_pct;
      cpu_pct = (seg % 2 == 0) ? 95 : 40;
      for (int c = 0; c < 400; c++) begin
        bus.cpu_cs     = ($urandom_range(99) < cpu_pct);
        bus.cpu_we     = 1'($urandom_range(1));
        bus.cpu_addr   = 32'($urandom_range(32, 63)) << 2;
        bus.cpu_wdata  = $urandom;
        bus.host_valid = ($urandom_range(99) < 35);
        bus.host_we    = 1'($urandom_range(1));
        bus.host_addr  = 32'($urandom_range(32, 63)) << 2;
        bus.host_wdata = $urandom;
        tick();
      end
      if (seg == 2) apply_reset();
    end
    idle_inputs();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
